quiz_round_ctrl: RTL

Round sequencer for the arithmetic-quiz game. It samples the free-running expression generator once per round and holds the expression and lane stable for display. It computes the expected answer, then waits for a player answer or a timeout. It judges the answer, keeps score and lives, and declares game over when lives reach zero.

---
 rtl/quiz_pkg.sv | 26 ++
 rtl/exp_eval.sv | 44 ++++
 rtl/quiz_round_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/quiz_pkg.sv
// Shared definitions for the arithmetic-quiz round sequencer: op codes,
// expression field positions and FSM state encoding.
package quiz_pkg;

   localparam logic [3:0] OP_ADD = 4'hA;
   localparam logic [3:0] OP_SUB = 4'hB;
   localparam logic [3:0] OP_MUL = 4'hC;
   localparam logic [3:0] OP_DIV = 4'hD;

   // Expression layout: {num1, op, num2}, one nibble each
   localparam int FIELD_W  = 4;
   localparam int NUM1_LSB = 8;
   localparam int OP_LSB   = 4;
   localparam int NUM2_LSB = 0;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOAD     = 3'd1;
   localparam logic [2:0] ST_WAIT     = 3'd2;
   localparam logic [2:0] ST_JUDGE    = 3'd3;
   localparam logic [2:0] ST_GAMEOVER = 3'd4;

   function automatic logic is_digit(input logic [3:0] v);
      return (v >= 4'd1) && (v <= 4'd9);
   endfunction

endpackage

// File: rtl/exp_eval.sv
// Combinational evaluator: computes the 7-bit answer of a quiz expression
// and flags whether the expression is a legal round.
module exp_eval
   import quiz_pkg::*;
(
   input  logic [11:0] exp,
   output logic [6:0]  answer,
   output logic        legal
);

   logic [3:0] num1;
   logic [3:0] op;
   logic [3:0] num2;
   logic [7:0] n1;
   logic [7:0] n2;
   logic [7:0] result;

   assign num1 = exp[NUM1_LSB +: FIELD_W];
   assign op   = exp[OP_LSB   +: FIELD_W];
   assign num2 = exp[NUM2_LSB +: FIELD_W];
   assign n1   = {4'd0, num1};
   assign n2   = {4'd0, num2};

   // Operands outside 1..9 make the round illegal, which also rules out /0
   always_comb begin
      result = 8'd0;
      legal  = is_digit(num1) && is_digit(num2);
      case (op)
         OP_ADD: result = n1 + n2;
         OP_SUB: begin
            result = n1 - n2;
            if (num1 < num2) legal = 1'b0;
         end
         OP_MUL: result = n1 * n2;
         OP_DIV: begin
            if (num2 != 4'd0) result = n1 / n2;
         end
         default: legal = 1'b0;
      endcase
   end

   assign answer = result[6:0];

endmodule

// File: rtl/quiz_round_ctrl.sv
// Round sequencer for the arithmetic quiz: latches an expression per round,
// times the player's answer, judges it and keeps score and lives.
module quiz_round_ctrl
   import quiz_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int LIVES          = 3,
   parameter int SCORE_W        = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [11:0]        gen_exp,
   input  logic [1:0]         gen_line,
   input  logic               ans_valid,
   input  logic [6:0]         ans_value,
   input  logic [1:0]         ans_line,
   output logic [11:0]        cur_exp,
   output logic [1:0]         cur_line,
   output logic               exp_valid,
   output logic [31:0]        timer,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         lives,
   output logic               hit,
   output logic               miss,
   output logic               game_over
);

   localparam logic [31:0]        TIMER_INIT = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

   logic [2:0]         state_q,     state_d;
   logic [11:0]        cur_exp_q,   cur_exp_d;
   logic [1:0]         cur_line_q,  cur_line_d;
   logic               exp_valid_q, exp_valid_d;
   logic [31:0]        timer_q,     timer_d;
   logic [SCORE_W-1:0] score_q,     score_d;
   logic [3:0]         lives_q,     lives_d;
   logic               hit_q,       hit_d;
   logic               miss_q,      miss_d;
   logic               game_over_q, game_over_d;
   logic [6:0]         expected_q,  expected_d;
   logic               legal_q,     legal_d;

   logic [6:0] eval_answer;
   logic       eval_legal;
   logic       judge;
   logic       match;

   exp_eval u_exp_eval (
      .exp    (gen_exp),
      .answer (eval_answer),
      .legal  (eval_legal)
   );

   // Judgement outputs (hit/miss, score, lives) become visible during JUDGE
   always_comb begin
      state_d     = state_q;
      cur_exp_d   = cur_exp_q;
      cur_line_d  = cur_line_q;
      exp_valid_d = exp_valid_q;
      timer_d     = timer_q;
      score_d     = score_q;
      lives_d     = lives_q;
      hit_d       = 1'b0;
      miss_d      = 1'b0;
      game_over_d = game_over_q;
      expected_d  = expected_q;
      legal_d     = legal_q;
      judge       = 1'b0;
      match       = 1'b0;

      case (state_q)
         ST_IDLE, ST_GAMEOVER: begin
            if (start) begin
               score_d     = '0;
               lives_d     = LIVES_INIT;
               game_over_d = 1'b0;
               state_d     = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cur_exp_d   = gen_exp;
            cur_line_d  = gen_line;
            expected_d  = eval_answer;
            legal_d     = eval_legal;
            timer_d     = TIMER_INIT;
            exp_valid_d = 1'b1;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            // An answer arriving with the final timer tick still wins
            if (ans_valid) begin
               judge = 1'b1;
               match = (ans_value == expected_q) && (ans_line == cur_line_q) && legal_q;
            end else if (timer_q == 32'd0) begin
               judge = 1'b1;
            end else begin
               timer_d = timer_q - 32'd1;
            end
            if (judge) begin
               exp_valid_d = 1'b0;
               state_d     = ST_JUDGE;
               if (match) begin
                  hit_d = 1'b1;
                  if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
               end else begin
                  miss_d = 1'b1;
                  if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
               end
            end
         end
         ST_JUDGE: begin
            if (lives_q == 4'd0) begin
               game_over_d = 1'b1;
               state_d     = ST_GAMEOVER;
            end else begin
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cur_exp_q   <= 12'd0;
         cur_line_q  <= 2'd0;
         exp_valid_q <= 1'b0;
         timer_q     <= 32'd0;
         score_q     <= '0;
         lives_q     <= LIVES_INIT;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         game_over_q <= 1'b0;
         expected_q  <= 7'd0;
         legal_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_exp_q   <= cur_exp_d;
         cur_line_q  <= cur_line_d;
         exp_valid_q <= exp_valid_d;
         timer_q     <= timer_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         game_over_q <= game_over_d;
         expected_q  <= expected_d;
         legal_q     <= legal_d;
      end
   end

   assign cur_exp   = cur_exp_q;
   assign cur_line  = cur_line_q;
   assign exp_valid = exp_valid_q;
   assign timer     = timer_q;
   assign score     = score_q;
   assign lives     = lives_q;
   assign hit       = hit_q;
   assign miss      = miss_q;
   assign game_over = game_over_q;

endmodule
